// File: rtl/game_round_ctrl.sv
// game_round_ctrl: sequences one timed whack-a-mole round.
// IDLE -> ARM (1 cycle) -> RUN (counts down GAME_SECONDS) -> DONE.
// Emits a level start_out enable, a periodic change_out relight strobe whose
// spacing shrinks as the live score rises, and latches final/high score.
// Optional macro PAUSE_CTRL_EN adds a pause input that freezes a running round.
module game_round_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned GAME_SECONDS  = 30,
  parameter int unsigned BASE_INTERVAL = 25000000,
  parameter int unsigned STEP          = 2500000,
  parameter int unsigned MIN_INTERVAL  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [6:0] score_in,
`ifdef PAUSE_CTRL_EN
  input  logic       pause,
`endif
  output logic       start_out,
  output logic       change_out,
  output logic [5:0] time_left,
  output logic       game_over,
  output logic [6:0] final_score,
  output logic [6:0] high_score,
  output logic       new_record
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  localparam logic [5:0]  GS6   = 6'(GAME_SECONDS);
  localparam logic [31:0] TLAST = 32'(TICKS_PER_SEC) - 32'd1;
  localparam logic [31:0] BASE  = 32'(BASE_INTERVAL);
  localparam logic [31:0] MINI  = 32'(MIN_INTERVAL);

  state_t      state, state_nx;
  logic [31:0] presc, icnt;
  logic [31:0] step_total, cur_interval;
  logic        run_en, presc_wrap, int_hit, fin_wrap;

  // Interval shrinks by STEP every 8 points; saturate at the floor, never negative.
  always_comb begin
    step_total   = 32'(STEP) * {28'd0, score_in[6:3]};
    cur_interval = MINI;
    if (step_total < BASE && (BASE - step_total) > MINI)
      cur_interval = BASE - step_total;
  end

  // Run qualifiers: a paused round behaves as if time stood still.
  always_comb begin
    run_en     = (state == RUN);
`ifdef PAUSE_CTRL_EN
    run_en     = (state == RUN) && !pause;
`endif
    presc_wrap = run_en && (presc == TLAST);
    int_hit    = run_en && (icnt >= cur_interval - 32'd1);
    fin_wrap   = presc_wrap && (time_left == 6'd1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; go is only honoured from IDLE or DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = ARM;
      ARM:     state_nx = RUN;
      RUN:     if (fin_wrap) state_nx = DONE;
      DONE:    if (go) state_nx = ARM;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; the final-second wrap suppresses any coincident strobe.
  always_comb begin
    start_out  = (state == ARM) || (state == RUN);
    change_out = (state == ARM) || (int_hit && !fin_wrap);
    game_over  = (state == DONE);
  end

  // Round datapath: prescaler, interval counter, countdown and score latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc       <= '0;
      icnt        <= '0;
      time_left   <= GS6;
      final_score <= '0;
      high_score  <= '0;
      new_record  <= 1'b0;
    end else begin
      if (state == ARM) begin
        presc     <= '0;
        icnt      <= '0;
        time_left <= GS6;
      end else if (run_en) begin
        presc <= presc_wrap ? '0 : presc + 32'd1;
        icnt  <= int_hit ? '0 : icnt + 32'd1;
        if (presc_wrap) time_left <= time_left - 6'd1;
      end
      if (fin_wrap) begin
        final_score <= score_in;
        if (score_in > high_score) begin
          high_score <= score_in;
          new_record <= 1'b1;
        end else begin
          new_record <= 1'b0;
        end
      end else if (go && (state == IDLE || state == DONE)) begin
        // cleared on the way into ARM so the flag is low for the whole new round
        new_record <= 1'b0;
      end
    end
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Sequences one timed whack-a-mole round for the LED scoring datapath.
- Turns a player "go" pulse into the level-sensitive `start_out` enable and a periodic one-cycle `change_out` strobe, which tells the scorer to relight an LED from the LFSR.
- Counts down the round time and latches the final score and the session high score.
- The LED change interval shortens as the live score rises (difficulty ramp).

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second tick.
- GAME_SECONDS, 30, round length in seconds (1..63).
- BASE_INTERVAL, 25000000, clk cycles between change strobes at score 0.
- STEP, 2500000, interval reduction per 8 points of score.
- MIN_INTERVAL, 5000000, floor on the change interval.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- go  in  1  debounced one-cycle start pulse
- score_in  in  7  live score from the scoring datapath
- start_out  in→out  1  level enable to the scorer; out, held high during RUN
- change_out  out  1  one-cycle relight strobe
- time_left  out  6  seconds remaining
- game_over  out  1  high in DONE
- final_score  out  7  score latched at round end
- high_score  out  7  best final score since reset
- new_record  out  1  high in DONE if final_score exceeded the previous high_score

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, except time_left=GAME_SECONDS. Prescaler and interval counter cleared.
- States are IDLE, ARM, RUN, DONE.
- IDLE -> ARM on go=1.
- ARM lasts exactly 1 cycle:
  - start_out rises.
  - time_left=GAME_SECONDS.
  - Prescaler and interval counter cleared.
  - change_out=1 in this cycle so the first LED lights immediately.
- ARM -> RUN unconditionally.
- RUN, prescaler:
  - Counts 0..TICKS_PER_SEC-1.
  - On wrap, time_left decrements.
- RUN, interval counter:
  - Counts up each cycle.
  - When count >= cur_interval-1: change_out=1 for one cycle and the counter clears.
- cur_interval = max(MIN_INTERVAL, BASE_INTERVAL - STEP*(score_in>>3)).
  - Computed combinationally, 32-bit unsigned.
  - The subtraction saturates at MIN_INTERVAL, never going negative.
- RUN -> DONE when time_left==1 and the prescaler wraps (time_left becomes 0). On that cycle:
  - start_out falls.
  - change_out is forced 0, even if an interval expiry coincides.
  - final_score <= score_in.
  - If score_in > high_score: high_score <= score_in and new_record <= 1; else new_record <= 0.
- go during RUN is ignored.
- DONE: game_over=1, start_out=0; all other outputs hold.
- DONE -> ARM on go=1. game_over and new_record clear in ARM; high_score is retained.
- Reset mid-RUN: immediate return to IDLE values. high_score is lost.
- Width rule: score comparisons are unsigned 7-bit.

Optional Feature:
- Macro PAUSE_CTRL_EN adds input `pause` (1 bit).
- With the macro, in RUN with pause=1:
  - Prescaler, time_left and interval counter freeze.
  - change_out is held 0.
  - start_out stays 1, so the scorer does not reset.
  - On pause release, counting resumes from the frozen values.
  - pause has no effect in IDLE, ARM or DONE.
- Without the macro: the port is absent and behaviour is as above.

Test Plan:
- Reset, then idle: hold rst=0 mid-cycle -> all outputs 0 asynchronously, time_left=GAME_SECONDS. No activity without go.
- Basic round (TICKS_PER_SEC=10, GAME_SECONDS=3, BASE_INTERVAL=4, STEP=1, MIN_INTERVAL=2, score_in=0): pulse go.
  - change_out in ARM cycle, then every 4 cycles.
  - time_left 3→2→1→0 at 10-cycle spacing.
  - start_out high exactly 31 cycles (ARM + 30 RUN).
  - game_over then asserts.
- Difficulty ramp (same params): drive score_in=8 -> spacing 3 cycles. score_in=16 -> 2. score_in=40 -> stays 2 (floor).
- Record tracking:
  - Round 1 ends with score_in=12 -> final_score=12, high_score=12, new_record=1.
  - Round 2 ends with score_in=9 -> final_score=9, high_score=12, new_record=0.
- Boundary:
  - Interval expiry on the same cycle as the final second wrap -> no change_out, start_out falls.
  - go during RUN -> no restart.
  - rst pulse mid-RUN -> IDLE, high_score=0.
- With PAUSE_CTRL_EN: pause=1 for 7 cycles mid-RUN -> time_left and strobe phase unchanged, start_out=1 throughout, round extends by exactly 7 cycles.
